memory_controller: RTL
======================

Name: memory_controller

Overview:
- Single owner of the byte-wide RAM/IO bus.
- Arbitrates between the instruction fetcher (word reads only) and the load/store buffer (byte/half/word reads and writes).
- Serialises each request into byte beats on the RAM port and returns assembled data with a one-cycle ready pulse.
- Honours pipeline clear and IO back-pressure.

Parameters:
- ADDR_WIDTH, 32, RAM/IO address width.
- IO_BASE, 32'h00030000, addresses >= IO_BASE are the IO region; stores to it obey io_buffer_full.

Ports:
- clk_in  input  1  system clock; all state changes on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; low freezes the block.
- _clear  input  1  pipeline flush.
- _if_mem_ready  input  1  fetcher request, level, held until _mem_if_ready.
- _if_addr  input  ADDR_WIDTH  fetch address.
- _mem_if_ready  output  1  one-cycle pulse, fetch data valid.
- _mem_if_inst  output  32  fetched word.
- _lsb_mem_ready  input  1  LSB request, level, held until _mem_lsb_ready.
- _work_type  input  2  0=byte, 1=half, 2=word (3 treated as word).
- _r_nw_in  input  1  1=read, 0=write.
- _addr  input  ADDR_WIDTH  LSB address.
- _data_in  input  32  store data, low bytes used.
- _mem_lsb_ready  output  1  one-cycle pulse, load data valid / store done.
- _data_out  output  32  load data, zero-extended.
- _mem_busy  output  1  high whenever state != IDLE.
- mem_din  input  8  RAM read byte, valid one cycle after address.
- mem_dout  output  8  RAM write byte.
- mem_a  output  ADDR_WIDTH  RAM address.
- mem_wr  output  1  1=write this cycle.
- io_buffer_full  input  1  IO sink cannot take a byte.

Behaviour:
- States: IDLE, READ, WRITE. Byte counter c (0..4). Latched: addr, length n (1/2/4), write data, owner (IF/LSB).
- Reset (rst_in=0, async): state=IDLE, c=0. Outputs: _mem_if_ready=0, _mem_lsb_ready=0, _mem_if_inst=0, _data_out=0, _mem_busy=0, mem_a=0, mem_dout=0, mem_wr=0. Reset mid-transfer abandons it; no ready pulse.
- rdy_in=0: all registers hold; mem_wr forced 0.
- IDLE arbitration at an edge:
  - _clear=1: accept nothing.
  - Else, if _lsb_mem_ready: grant LSB (fixed LSB priority).
  - Else, if _if_mem_ready: grant IF, n=4, read.
  - On grant: latch request, c=0, go to READ or WRITE.
- READ:
  - mem_a=addr+c, mem_wr=0.
  - At each edge with c>0, mem_din is stored into byte c-1; c increments.
  - At the edge where c==n: capture the last byte, pulse the owner's ready with the assembled data (upper bytes 0), go to IDLE.
  - Word read: 5 edges from accept to ready; byte read: 2.
- WRITE:
  - mem_a=addr+c, mem_dout=data byte c, mem_wr=1.
  - Last beat c==n-1; at the following edge pulse _mem_lsb_ready, go to IDLE.
  - Latency n edges.
  - If addr>=IO_BASE and io_buffer_full=1: mem_wr=0 and c holds until full drops.
- Ready pulses last exactly one cycle.
- A new request is accepted no earlier than the edge after the pulse, because the pulse cycle is spent in IDLE.
- _clear in READ: abort at that edge, go to IDLE, no pulse, captured data discarded.
- _clear in WRITE: ignored; committed stores always complete.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Little-endian: byte c maps to bits [8c+7:8c].

Test Plan:
- IF word read at 0x100, RAM bytes 13,00,00,93 -> _mem_if_ready pulses 5 edges after accept, _mem_if_inst=0x93000013; mem_a steps 0x100..0x103.
- LSB half read at 0x200 (bytes 0xCD,0xAB) while the IF request is also pending -> LSB served first, _data_out=0x0000ABCD; the IF read starts the edge after the LSB pulse.
- LSB byte write of 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr low for those 3 cycles, then one beat with mem_dout=0x41, pulse one edge later.
- IF word read, _clear asserted at c=2 -> no _mem_if_ready; IDLE next cycle; a fresh request is accepted on the following edge.
- Word store 0xDEADBEEF to 0x10, _clear at c=1 -> all 4 beats written (EF,BE,AD,DE), _mem_lsb_ready pulses.
- rdy_in low for 2 cycles mid word-read, then rst_in pulsed low mid-write -> state frozen during rdy_in low; on reset all outputs go to 0 immediately and no ready pulse appears.

Source files
------------

// File: rtl/memory_controller.sv
// Byte-wide RAM/IO bus owner: arbitrates fetcher and load/store buffer requests,
// serialises them into little-endian byte beats and returns assembled data.
module memory_controller #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h00030000)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  _clear,
    input  logic                  _if_mem_ready,
    input  logic [ADDR_WIDTH-1:0] _if_addr,
    output logic                  _mem_if_ready,
    output logic [31:0]           _mem_if_inst,
    input  logic                  _lsb_mem_ready,
    input  logic [1:0]            _work_type,
    input  logic                  _r_nw_in,
    input  logic [ADDR_WIDTH-1:0] _addr,
    input  logic [31:0]           _data_in,
    output logic                  _mem_lsb_ready,
    output logic [31:0]           _data_out,
    output logic                  _mem_busy,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    typedef enum logic {OWN_IF, OWN_LSB} owner_t;

    state_t                state_reg, state_next;
    owner_t                owner_reg, owner_next;
    logic [2:0]            cnt_reg, cnt_next;
    logic [2:0]            len_reg, len_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic [31:0]           rdata_reg, rdata_next;
    logic [31:0]           inst_reg, inst_next;
    logic [31:0]           dout_reg, dout_next;
    logic                  if_ready_reg, if_ready_next;
    logic                  lsb_ready_reg, lsb_ready_next;

    logic [31:0] merged;
    logic [1:0]  cap_idx;
    logic [7:0]  wr_bytes [4];
    logic        io_stall;

    // mem_din answers the address presented one beat earlier, hence lane c-1
    assign cap_idx = 2'(cnt_reg - 3'd1);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = (cap_idx == 2'(gi)) ? mem_din : rdata_reg[8*gi +: 8];
            assign wr_bytes[gi]      = wdata_reg[8*gi +: 8];
        end
    endgenerate

    assign io_stall = (addr_reg >= IO_BASE) && io_buffer_full;

    assign mem_a          = (state_reg == IDLE) ? '0 : addr_reg + ADDR_WIDTH'(cnt_reg);
    assign mem_dout       = (state_reg == WRITE) ? wr_bytes[cnt_reg[1:0]] : 8'h00;
    assign mem_wr         = (state_reg == WRITE) && rdy_in && !io_stall;
    assign _mem_busy      = (state_reg != IDLE);
    assign _mem_if_ready  = if_ready_reg;
    assign _mem_lsb_ready = lsb_ready_reg;
    assign _mem_if_inst   = inst_reg;
    assign _data_out      = dout_reg;

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        cnt_next       = cnt_reg;
        len_next       = len_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        rdata_next     = rdata_reg;
        inst_next      = inst_reg;
        dout_next      = dout_reg;
        if_ready_next  = 1'b0;
        lsb_ready_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!_clear && _lsb_mem_ready) begin
                    owner_next = OWN_LSB;
                    addr_next  = _addr;
                    wdata_next = _data_in;
                    rdata_next = '0;
                    cnt_next   = 3'd0;
                    case (_work_type)
                        2'd0:    len_next = 3'd1;
                        2'd1:    len_next = 3'd2;
                        default: len_next = 3'd4;
                    endcase
                    state_next = _r_nw_in ? READ : WRITE;
                end else if (!_clear && _if_mem_ready) begin
                    owner_next = OWN_IF;
                    addr_next  = _if_addr;
                    rdata_next = '0;
                    cnt_next   = 3'd0;
                    len_next   = 3'd4;
                    state_next = READ;
                end
            end
            READ: begin
                if (_clear) begin
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                end else if (cnt_reg == len_reg) begin
                    state_next = IDLE;
                    cnt_next   = 3'd0;
                    rdata_next = merged;
                    if (owner_reg == OWN_IF) begin
                        inst_next     = merged;
                        if_ready_next = 1'b1;
                    end else begin
                        dout_next      = merged;
                        lsb_ready_next = 1'b1;
                    end
                end else begin
                    if (cnt_reg != 3'd0) rdata_next = merged;
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            WRITE: begin
                // stores are committed: a flush never cuts a write short
                if (!io_stall) begin
                    if (cnt_reg == len_reg - 3'd1) begin
                        state_next     = IDLE;
                        cnt_next       = 3'd0;
                        lsb_ready_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_IF;
            cnt_reg       <= 3'd0;
            len_reg       <= 3'd0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            inst_reg      <= '0;
            dout_reg      <= '0;
            if_ready_reg  <= 1'b0;
            lsb_ready_reg <= 1'b0;
        end else if (rdy_in) begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            cnt_reg       <= cnt_next;
            len_reg       <= len_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rdata_reg     <= rdata_next;
            inst_reg      <= inst_next;
            dout_reg      <= dout_next;
            if_ready_reg  <= if_ready_next;
            lsb_ready_reg <= lsb_ready_next;
        end
    end

endmodule
